// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide share one 2*XLEN accumulator and a single (XLEN+1)-bit adder.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide iteration per cycle, cnt_q counts down to 0
// FIX   | sign correction and result select (or fast-path result)
// DONE  | result valid, done strobe; may accept the next op
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d, fast_q, fast_d;
  logic [4:0]        rd_q, rd_d, rd_out_q, rd_out_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg_in, b_neg_in, div_zero, div_ovf, fast_in, accept;
  logic [XLEN-1:0]   a_mag, b_mag, fast_res;
  logic              is_div;
  logic [XLEN:0]     add_top, add_b;
  logic [XLEN+1:0]   add_sum;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg_in = a_signed && rs1_data[XLEN-1];
    b_neg_in = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg_in ? -rs1_data : rs1_data;
    b_mag    = b_neg_in ? -rs2_data : rs2_data;
    div_zero = (rs2_data == '0);
    div_ovf  = !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
    fast_in  = funct3[2] && (div_zero || div_ovf);
    fast_res = div_zero ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : MIN_NEG);
  end

  // Divide subtracts the divisor from the shifted partial remainder; the carry out
  // of the shared adder is the "no borrow" quotient bit.
  always_comb begin
    is_div  = op_q[2];
    add_top = is_div ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
    add_b   = is_div ? ~{1'b0, opb_q} : (acc_q[0] ? {1'b0, opb_q} : '0);
    add_sum = {1'b0, add_top} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, is_div};
    if (is_div) begin
      acc_step = add_sum[XLEN+1] ? {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                 : {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_step = {add_sum[XLEN:0], acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quot_fix = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (fast_q) begin
      fix_res = acc_q[XLEN-1:0];
    end else begin
      case (op_q)
        3'd0:                fix_res = prod_fix[XLEN-1:0];
        3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*XLEN-1:XLEN];
        3'd4, 3'd5:          fix_res = quot_fix;
        default:             fix_res = rem_fix;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    fast_d   = fast_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !kill;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d    = funct3;
          rd_d    = rd_addr;
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          fast_d  = fast_in;
          opb_d   = b_mag;
          cnt_d   = CNT_W'(XLEN-1);
          acc_d   = {{XLEN{1'b0}}, (fast_in ? fast_res : a_mag)};
          state_d = fast_in ? S_FIX : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = S_DONE;
        result_d = fix_res;
        rd_out_d = rd_q;
      end
    endcase

    // An aborted op must never reach DONE nor touch the visible outputs.
    if (kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      fast_q   <= 1'b0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      fast_q   <= fast_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign rd_out = rd_out_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: RV32M arithmetic model with per-op timing expectations,
// checked every cycle, plus directed cases with hand-computed results.
module tb_muldiv_unit;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, done;
  logic [4:0]  rd_out;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          busy_from;
    int          busy_to;
    int          done_cyc;
    logic [31:0] res;
    logic [4:0]  rd;
  } op_t;

  op_t         pq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_rd = '0;
  int          dut_done_cyc = -1;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        ea, eb, p;
    logic signed [31:0] sa, sb;
    logic               ovf;
    ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p   = ea * eb;
    sa  = a;
    sb  = b;
    ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0:             return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:             return (b == 0) ? 32'hFFFF_FFFF : (ovf ? MIN_NEG : 32'(sa / sb));
      3'd5:             return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:             return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default:          return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit accepting();
    return !rst && !kill && (pq.size() == 0 || (pq.size() == 1 && pq[0].done_cyc == cyc));
  endfunction

  function automatic void model_issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    op_t e;
    bit  fast;
    fast        = f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
    e.busy_from = cyc + 1;
    e.done_cyc  = cyc + (fast ? 2 : 34);
    e.busy_to   = e.done_cyc;
    e.res       = ref_result(f, a, b);
    e.rd        = rd;
    pq.push_back(e);
  endfunction

  function automatic void model_kill(input int n);
    foreach (pq[i]) begin
      if (pq[i].done_cyc > n) begin
        pq[i].done_cyc = -1;
        if (pq[i].busy_to > n + 1) pq[i].busy_to = n + 1;
      end
    end
  endfunction

  function automatic void model_reset();
    pq.delete();
    exp_result = '0;
    exp_rd     = '0;
  endfunction

  always @(negedge clk) begin : cmp
    logic bexp, dexp;
    bexp = 1'b0;
    dexp = 1'b0;
    foreach (pq[i]) if (pq[i].busy_from <= cyc && cyc < pq[i].busy_to) bexp = 1'b1;
    if (pq.size() > 0 && pq[0].done_cyc == cyc) begin
      dexp       = 1'b1;
      exp_result = pq[0].res;
      exp_rd     = pq[0].rd;
    end
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].done_cyc == cyc || (pq[i].done_cyc < 0 && cyc + 1 >= pq[i].busy_to)) pq.delete(i);
    end
    if (done === 1'b1) dut_done_cyc = cyc;
    tests++;
    if (busy !== bexp || done !== dexp || result !== exp_result || rd_out !== exp_rd) begin
      fails++;
      $display("FAIL cycle_cmp cyc=%0d busy/done/rd/result got %b %b %0d %h, expected %b %b %0d %h",
               cyc, busy, done, rd_out, result, bexp, dexp, exp_rd, exp_result);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start    = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    if (accepting()) model_issue(f, a, b, rd);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (pq.size() != 0 && k < 200) begin
      step();
      k++;
    end
    if (pq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_idle timeout: got %0d pending ops, expected 0", pq.size());
      pq.delete();
    end
  endtask

  task automatic wait_done_cycle();
    int k = 0;
    while (!(pq.size() > 0 && pq[0].done_cyc == cyc) && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) begin
      tests++;
      fails++;
      $display("FAIL wait_done timeout: got no done cycle, expected one within 200 cycles");
    end
  endtask

  logic [2:0]  d_f[11]   = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a[11]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[11]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp[11] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
  int          d_lat[11] = '{34, 34, 34, 34, 34, 34, 34, 2, 2, 2, 2};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s, d1;
    logic [31:0] prev, a, b;
    logic [2:0]  f;
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (2) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    rst = 1'b0;
    step();

    check("model_mul", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    s = cyc;
    send(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    wait_idle();
    check("mul_result", result, 32'hFFFF_FFEB);
    check("mul_rd", 32'(rd_out), 32'd9);
    check("mul_latency", 32'(dut_done_cyc - s), 32'd34);

    for (int i = 0; i < 11; i++) begin
      check($sformatf("model_dir%0d", i), ref_result(d_f[i], d_a[i], d_b[i]), d_exp[i]);
      s = cyc;
      send(d_f[i], d_a[i], d_b[i], 5'(i + 1));
      wait_idle();
      check($sformatf("dir%0d_result", i), result, d_exp[i]);
      check($sformatf("dir%0d_latency", i), 32'(dut_done_cyc - s), 32'(d_lat[i]));
    end

    // start pulsed mid-CALC must not be accepted
    s = cyc;
    send(3'd0, 32'd3, 32'd5, 5'd4);
    repeat (5) step();
    send(3'd5, 32'd77, 32'd0, 5'd30);
    wait_idle();
    check("ignore_result", result, 32'd15);
    check("ignore_latency", 32'(dut_done_cyc - s), 32'd34);

    // back-to-back start in DONE
    send(3'd3, 32'd10, 32'd20, 5'd5);
    wait_done_cycle();
    d1 = cyc;
    send(3'd0, 32'd6, 32'd7, 5'd6);
    wait_idle();
    check("b2b_result", result, 32'd42);
    check("b2b_gap", 32'(dut_done_cyc - d1), 32'd34);

    // kill at CALC cycle 10
    prev = exp_result;
    s = cyc;
    send(3'd0, 32'd9, 32'd9, 5'd3);
    repeat (9) step();
    kill = 1'b1;
    model_kill(cyc);
    step();
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_result", result, prev);
    repeat (40) step();
    check("kill_no_done", 32'(dut_done_cyc < s), 32'd1);
    wait_idle();

    // kill together with start during DONE
    send(3'd5, 32'd100, 32'd7, 5'd12);
    wait_done_cycle();
    kill = 1'b1;
    start = 1'b1;
    model_kill(cyc);
    step();
    kill = 1'b0;
    start = 1'b0;
    step();
    check("killdone_busy", 32'(busy), 32'd0);
    check("killdone_result", result, 32'd14);
    wait_idle();

    // reset mid-CALC
    send(3'd0, 32'h1234, 32'h5678, 5'd7);
    repeat (5) step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd", 32'(rd_out), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    send(3'd0, 32'd3, 32'd4, 5'd1);
    wait_idle();
    check("post_rst_mul", result, 32'd12);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: begin a = -$urandom_range(0, 300); b = -$urandom_range(1, 20); end
        default: ;
      endcase
      if (pq.size() > 0 && $urandom_range(0, 2) == 0) wait_done_cycle();
      else wait_idle();
      send(f, a, b, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) begin
        repeat (3) step();
        send(3'($urandom_range(0, 7)), $urandom(), $urandom(), 5'($urandom_range(0, 31)));
      end
    end
    wait_idle();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
